// File: rtl/hwpe_ctrl_package.sv
// Shared microcode types and the serialized image geometry used by the
// microcode loader and the microcode engine.
package hwpe_ctrl_package;

    localparam int unsigned UCODE_LENGTH    = 16;
    localparam int unsigned UCODE_NB_LOOPS  = 6;
    localparam int unsigned UCODE_NB_REG    = 4;
    localparam int unsigned UCODE_NB_RO_REG = 28;
    localparam int unsigned UCODE_CNT_WIDTH = 16;

    localparam int unsigned UCODE_REG_W    = $clog2(UCODE_NB_REG + UCODE_NB_RO_REG);
    localparam int unsigned UCODE_ADDR_W   = $clog2(UCODE_LENGTH);
    localparam int unsigned UCODE_NB_OPS_W = 3;

    typedef struct packed {
        logic                   op_sel;
        logic [UCODE_REG_W-1:0] a;
        logic [UCODE_REG_W-1:0] b;
    } ucode_code_t;

    typedef struct packed {
        logic [UCODE_NB_OPS_W-1:0] nb_ops;
        logic [UCODE_ADDR_W-1:0]   ucode_addr;
    } ucode_loop_t;

    typedef struct packed {
        ucode_code_t [UCODE_LENGTH-1:0]                          code;
        ucode_loop_t [UCODE_NB_LOOPS-1:0]                        loops;
        logic        [UCODE_NB_LOOPS-1:0][UCODE_CNT_WIDTH-1:0] range;
    } ucode_t;

    // Image section sizes: 2 code entries, 4 loops or 2 ranges per 32-bit word.
    function automatic int unsigned code_words(input int unsigned length);
        return length / 2;
    endfunction

    function automatic int unsigned loop_words(input int unsigned nb_loops);
        return (nb_loops + 3) / 4;
    endfunction

    function automatic int unsigned range_words(input int unsigned nb_loops);
        return (nb_loops + 1) / 2;
    endfunction

    localparam int unsigned UCODE_CODE_WORDS  = code_words(UCODE_LENGTH);
    localparam int unsigned UCODE_LOOP_WORDS  = loop_words(UCODE_NB_LOOPS);
    localparam int unsigned UCODE_RANGE_WORDS = range_words(UCODE_NB_LOOPS);
    localparam int unsigned UCODE_IMG_WORDS   = UCODE_CODE_WORDS + UCODE_LOOP_WORDS + UCODE_RANGE_WORDS;

    typedef enum logic [2:0] {
        LDR_IDLE,
        LDR_CODE,
        LDR_LOOPS,
        LDR_RANGES,
        LDR_COMMIT
    } ldr_state_e;

endpackage

// File: rtl/hwpe_ctrl_ucode_checker.sv
// Combinational sanity check of a loaded loop table: every loop must have
// work to do, stay inside the code memory and iterate at least once.
module hwpe_ctrl_ucode_checker
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned LENGTH    = UCODE_LENGTH,
    parameter int unsigned NB_LOOPS  = UCODE_NB_LOOPS,
    parameter int unsigned CNT_WIDTH = UCODE_CNT_WIDTH
) (
    input  ucode_loop_t [NB_LOOPS-1:0]                 loops_i,
    input  logic        [NB_LOOPS-1:0][CNT_WIDTH-1:0] range_i,
    output logic                                       pass_o
);

    localparam int unsigned SUM_W = $clog2(LENGTH) + 1;

    always_comb begin
        pass_o = 1'b1;
        for (int l = 0; l < NB_LOOPS; l++) begin
            if (loops_i[l].nb_ops == '0 ||
                ({1'b0, loops_i[l].ucode_addr} + SUM_W'(loops_i[l].nb_ops)) > SUM_W'(LENGTH) ||
                range_i[l] == '0) begin
                pass_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/hwpe_ctrl_ucode_loader.sv
// Streams a serialized microcode image into shadow registers and commits it
// atomically to the engine once validated and the engine is not busy.
//
// state      | meaning
// -----------+----------------------------------------------------------
// LDR_IDLE   | no load in progress, waiting for start
// LDR_CODE   | accepting code words (2 entries per word)
// LDR_LOOPS  | accepting loop descriptor words (4 loops per word)
// LDR_RANGES | accepting loop range words (2 ranges per word)
// LDR_COMMIT | image complete, waiting for engine unlock, then commit/reject
module hwpe_ctrl_ucode_loader
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned LENGTH    = UCODE_LENGTH,
    parameter int unsigned NB_LOOPS  = UCODE_NB_LOOPS,
    parameter int unsigned NB_REG    = UCODE_NB_REG,
    parameter int unsigned NB_RO_REG = UCODE_NB_RO_REG,
    parameter int unsigned CNT_WIDTH = UCODE_CNT_WIDTH
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        test_mode_i,
    input  logic        clear_i,
    input  logic        start_i,
    input  logic        lock_i,
    input  logic [31:0] cfg_data_i,
    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    output ucode_t      ucode_o,
    output logic        ucode_valid_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam int unsigned REG_W      = $clog2(NB_REG + NB_RO_REG);
    localparam int unsigned ENTRY_W    = 1 + 2 * REG_W;
    localparam int unsigned LOOP_W     = $bits(ucode_loop_t);
    localparam int unsigned LOOP_BASE  = code_words(LENGTH);
    localparam int unsigned RANGE_BASE = LOOP_BASE + loop_words(NB_LOOPS);
    localparam int unsigned IMG_WORDS  = RANGE_BASE + range_words(NB_LOOPS);
    localparam int unsigned WCNT_W     = $clog2(IMG_WORDS);

    typedef logic [WCNT_W-1:0] wcnt_t;

    ldr_state_e state_q, state_d;
    wcnt_t      cnt_q, cnt_d;
    ucode_t     shadow_q, active_q;
    logic       valid_q, err_q;
    logic       xfer, check_pass, commit_ok, commit_fail;
    logic       unused_test_mode;

    assign unused_test_mode = test_mode_i;

    assign cfg_ready_o = (state_q == LDR_CODE) || (state_q == LDR_LOOPS) || (state_q == LDR_RANGES);
    assign busy_o      = (state_q != LDR_IDLE);
    // A start in the same cycle as a handshake drops the word.
    assign xfer        = cfg_valid_i & cfg_ready_o & ~start_i;

    hwpe_ctrl_ucode_checker #(
        .LENGTH    ( LENGTH    ),
        .NB_LOOPS  ( NB_LOOPS  ),
        .CNT_WIDTH ( CNT_WIDTH )
    ) i_checker (
        .loops_i ( shadow_q.loops ),
        .range_i ( shadow_q.range ),
        .pass_o  ( check_pass     )
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        commit_ok   = 1'b0;
        commit_fail = 1'b0;
        if (start_i) begin
            state_d = LDR_CODE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                LDR_CODE: if (xfer) begin
                    cnt_d = cnt_q + wcnt_t'(1);
                    if (cnt_q == wcnt_t'(LOOP_BASE - 1)) state_d = LDR_LOOPS;
                end
                LDR_LOOPS: if (xfer) begin
                    cnt_d = cnt_q + wcnt_t'(1);
                    if (cnt_q == wcnt_t'(RANGE_BASE - 1)) state_d = LDR_RANGES;
                end
                LDR_RANGES: if (xfer) begin
                    cnt_d = cnt_q + wcnt_t'(1);
                    if (cnt_q == wcnt_t'(IMG_WORDS - 1)) state_d = LDR_COMMIT;
                end
                LDR_COMMIT: if (!lock_i) begin
                    state_d     = LDR_IDLE;
                    commit_ok   = check_pass;
                    commit_fail = ~check_pass;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= LDR_IDLE;
            cnt_q    <= '0;
            active_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else if (clear_i) begin
            state_q  <= LDR_IDLE;
            cnt_q    <= '0;
            active_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (start_i)          err_q <= 1'b0;
            else if (commit_fail) err_q <= 1'b1;
            if (commit_ok) begin
                active_q <= shadow_q;
                valid_q  <= 1'b1;
            end
        end
    end

    // The word counter is global across sections, so each field matches its absolute word index.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q <= '0;
        end else if (clear_i) begin
            shadow_q <= '0;
        end else if (xfer) begin
            case (state_q)
                LDR_CODE: for (int k = 0; k < LENGTH; k++) begin
                    if (cnt_q == wcnt_t'(k / 2))
                        shadow_q.code[k] <= ucode_code_t'(cfg_data_i[16*(k%2) +: ENTRY_W]);
                end
                LDR_LOOPS: for (int l = 0; l < NB_LOOPS; l++) begin
                    if (cnt_q == wcnt_t'(LOOP_BASE + l / 4))
                        shadow_q.loops[l] <= ucode_loop_t'(cfg_data_i[8*(l%4) +: LOOP_W]);
                end
                LDR_RANGES: for (int l = 0; l < NB_LOOPS; l++) begin
                    if (cnt_q == wcnt_t'(RANGE_BASE + l / 2))
                        shadow_q.range[l] <= cfg_data_i[16*(l%2) +: CNT_WIDTH];
                end
                default: ;
            endcase
        end
    end

    assign ucode_o       = active_q;
    assign ucode_valid_o = valid_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_hwpe_ctrl_ucode_loader.sv
// Self-checking bench for the microcode loader: table-driven image loads,
// hand-written abort/clear sequences and randomized images with gaps.
module tb_hwpe_ctrl_ucode_loader;
    import hwpe_ctrl_package::*;

    logic        clk_i = 1'b0;
    logic        rst_ni, test_mode_i, clear_i, start_i, lock_i;
    logic [31:0] cfg_data_i;
    logic        cfg_valid_i, cfg_ready_o, ucode_valid_o, busy_o, err_o;
    ucode_t      ucode_o;

    always #5 clk_i = ~clk_i;

    hwpe_ctrl_ucode_loader dut (
        .clk_i         ( clk_i         ),
        .rst_ni        ( rst_ni        ),
        .test_mode_i   ( test_mode_i   ),
        .clear_i       ( clear_i       ),
        .start_i       ( start_i       ),
        .lock_i        ( lock_i        ),
        .cfg_data_i    ( cfg_data_i    ),
        .cfg_valid_i   ( cfg_valid_i   ),
        .cfg_ready_o   ( cfg_ready_o   ),
        .ucode_o       ( ucode_o       ),
        .ucode_valid_o ( ucode_valid_o ),
        .busy_o        ( busy_o        ),
        .err_o         ( err_o         )
    );

    // High-level image description: what the programmer intends to load.
    typedef struct {
        logic [10:0] code [16];
        logic [3:0]  addr [6];
        logic [2:0]  nb   [6];
        logic [15:0] rng  [6];
    } img_t;

    typedef struct {
        int    kind;
        int    lock_cycles;
        logic  exp_err;
        string name;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] words [13];
    img_t        cur;
    ucode_t      model_u;
    logic        model_v;
    vec_t        vecs [7];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b required=%0b", name, act, exp);
        end
    endtask

    task automatic chk_u(input string name, input ucode_t act, input ucode_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic model_ok(input img_t m);
        for (int l = 0; l < 6; l++) begin
            if (m.nb[l] == 0) return 1'b0;
            if (int'(m.addr[l]) + int'(m.nb[l]) > 16) return 1'b0;
            if (m.rng[l] == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic ucode_t model_ucode(input img_t m);
        ucode_t u;
        u = '0;
        for (int k = 0; k < 16; k++) u.code[k] = ucode_code_t'(m.code[k]);
        for (int l = 0; l < 6; l++) begin
            u.loops[l].nb_ops     = m.nb[l];
            u.loops[l].ucode_addr = m.addr[l];
            u.range[l]            = m.rng[l];
        end
        return u;
    endfunction

    // Serialize cur into words; don't-care bits get random junk.
    task automatic build_words();
        for (int w = 0; w < 13; w++) words[w] = $urandom;
        for (int k = 0; k < 16; k++) words[k/2][16*(k%2) +: 11] = cur.code[k];
        for (int l = 0; l < 6; l++) words[8 + l/4][8*(l%4) +: 7] = {cur.nb[l], cur.addr[l]};
        for (int l = 0; l < 6; l++) words[10 + l/2][16*(l%2) +: 16] = cur.rng[l];
    endtask

    task automatic make_base();
        for (int k = 0; k < 16; k++) cur.code[k] = 11'($urandom_range(0, 2047));
        for (int l = 0; l < 6; l++) begin
            cur.addr[l] = (l == 0) ? 4'd0 : 4'd2;
            cur.nb[l]   = (l == 0) ? 3'd2 : 3'd1;
            cur.rng[l]  = 16'd3;
        end
    endtask

    task automatic apply_kind(input int kind);
        case (kind)
            1: cur.nb[2] = 3'd0;
            2: begin cur.addr[3] = 4'd14; cur.nb[3] = 3'd3; end
            3: cur.rng[4] = 16'd0;
            4: begin cur.addr[5] = 4'd13; cur.nb[5] = 3'd3; end
            5: begin cur.addr[1] = 4'd15; cur.nb[1] = 3'd7; end
            default: ;
        endcase
    endtask

    task automatic make_random();
        int bad_l;
        for (int k = 0; k < 16; k++) cur.code[k] = 11'($urandom_range(0, 2047));
        for (int l = 0; l < 6; l++) begin
            cur.nb[l]   = 3'($urandom_range(1, 7));
            cur.addr[l] = 4'($urandom_range(0, 16 - int'(cur.nb[l])));
            cur.rng[l]  = 16'($urandom_range(1, 65535));
        end
        if ($urandom_range(0, 2) == 0) begin
            bad_l = $urandom_range(0, 5);
            case ($urandom_range(0, 2))
                0: cur.nb[bad_l] = 3'd0;
                1: begin cur.addr[bad_l] = 4'd15; cur.nb[bad_l] = 3'($urandom_range(2, 7)); end
                default: cur.rng[bad_l] = 16'd0;
            endcase
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_pct);
        int n;
        n = 0;
        while ($urandom_range(0, 99) < gap_pct && n < 20) begin
            cfg_valid_i = 1'b0;
            cfg_data_i  = $urandom;
            tick();
            n++;
        end
        cfg_valid_i = 1'b1;
        cfg_data_i  = w;
        n = 0;
        while (!cfg_ready_o && n < 50) begin
            tick();
            n++;
        end
        if (!cfg_ready_o) begin
            errors++;
            $display("FAIL send_word_timeout actual_ready=0 required_ready=1");
        end
        tick();
        cfg_valid_i = 1'b0;
        cfg_data_i  = $urandom;
    endtask

    task automatic send_image(input int nwords, input int gap_pct);
        for (int i = 0; i < nwords; i++) send_word(words[i], gap_pct);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Entered one cycle after the last word was accepted (COMMIT state).
    task automatic commit_phase(input int lock_cycles, input logic exp_err);
        chk1("commit_busy", busy_o, 1'b1);
        for (int i = 0; i <= lock_cycles; i++) begin
            if (i == lock_cycles) lock_i = 1'b0;
            chk1("hold_ready_low", cfg_ready_o, 1'b0);
            chk1("hold_valid_old", ucode_valid_o, model_v);
            chk_u("hold_ucode_old", ucode_o, model_u);
            tick();
        end
        if (!exp_err) begin
            model_u = model_ucode(cur);
            model_v = 1'b1;
        end
        chk1("commit_err", err_o, exp_err);
        chk1("commit_valid", ucode_valid_o, model_v);
        chk_u("commit_ucode", ucode_o, model_u);
        chk1("commit_idle", busy_o, 1'b0);
    endtask

    task automatic full_load(input int lock_cycles, input logic exp_err, input int gap_pct);
        lock_i = (lock_cycles > 0);
        pulse_start();
        chk1("ready_after_start", cfg_ready_o, 1'b1);
        chk1("err_cleared_on_start", err_o, 1'b0);
        build_words();
        send_image(13, gap_pct);
        commit_phase(lock_cycles, exp_err);
    endtask

    initial begin
        vecs[0] = '{0, 0, 1'b0, "full_valid"};
        vecs[1] = '{0, 5, 1'b0, "lock_5"};
        vecs[2] = '{2, 0, 1'b1, "loop3_overflow"};
        vecs[3] = '{4, 0, 1'b0, "sum_eq_length"};
        vecs[4] = '{1, 0, 1'b1, "nb_ops_zero"};
        vecs[5] = '{3, 0, 1'b1, "range_zero"};
        vecs[6] = '{5, 2, 1'b1, "overflow_locked"};

        rst_ni = 1'b0; test_mode_i = 1'b0; clear_i = 1'b0; start_i = 1'b0;
        lock_i = 1'b0; cfg_valid_i = 1'b0; cfg_data_i = '0;
        model_u = '0; model_v = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        tick();
        chk_u("reset_ucode", ucode_o, '0);
        chk1("reset_valid", ucode_valid_o, 1'b0);
        chk1("reset_err", err_o, 1'b0);
        chk1("reset_busy", busy_o, 1'b0);
        chk1("reset_ready", cfg_ready_o, 1'b0);

        // Ready must stay low in IDLE even with valid asserted.
        cfg_valid_i = 1'b1;
        tick();
        chk1("idle_ready_with_valid", cfg_ready_o, 1'b0);
        cfg_valid_i = 1'b0;

        foreach (vecs[i]) begin
            make_base();
            apply_kind(vecs[i].kind);
            full_load(vecs[i].lock_cycles, vecs[i].exp_err, 0);
            chk1({vecs[i].name, "_err"}, err_o, vecs[i].exp_err);
        end

        // Abort after 6 words, with a dropped word coinciding with the restart.
        make_random();
        build_words();
        lock_i = 1'b0;
        pulse_start();
        send_image(6, 0);
        start_i     = 1'b1;
        cfg_valid_i = 1'b1;
        cfg_data_i  = $urandom;
        tick();
        start_i     = 1'b0;
        cfg_valid_i = 1'b0;
        chk1("abort_ready", cfg_ready_o, 1'b1);
        make_base();
        build_words();
        send_image(13, 0);
        commit_phase(0, 1'b0);

        // Randomized images with 50% valid gaps.
        for (int it = 0; it < 10; it++) begin
            make_random();
            full_load($urandom_range(0, 3), !model_ok(cur), 50);
        end

        // Clear in the middle of the RANGES section after a good commit.
        make_base();
        full_load(0, 1'b0, 0);
        pulse_start();
        build_words();
        send_image(11, 0);
        chk1("pre_clear_busy", busy_o, 1'b1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        model_u = '0;
        model_v = 1'b0;
        chk_u("clear_ucode", ucode_o, '0);
        chk1("clear_valid", ucode_valid_o, 1'b0);
        chk1("clear_err", err_o, 1'b0);
        chk1("clear_busy", busy_o, 1'b0);
        chk1("clear_ready", cfg_ready_o, 1'b0);

        // Loader must be fully usable after clear.
        make_random();
        full_load(0, !model_ok(cur), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hwpe_ctrl_ucode_loader.md
# hwpe_ctrl_ucode_loader

Writer side of the microcode interface. Accepts a serialized microcode image as 32-bit configuration words over a valid/ready stream, unpacks it into shadow registers, validates it, and atomically commits it to the `ucode_t` structure consumed by the HWPE microcode engine. Sits between the register-file/config path and the microcode engine, so the engine never observes a partially written program.

## Interface
- `LENGTH`, `UCODE_LENGTH` (16): number of code entries.
- `NB_LOOPS`, `UCODE_NB_LOOPS` (6): number of loops.
- `NB_REG`, `UCODE_NB_REG` (4): writable engine registers.
- `NB_RO_REG`, `UCODE_NB_RO_REG` (28): read-only engine registers; `a`/`b` fields are `$clog2(NB_REG+NB_RO_REG)` = 5 bits.
- `CNT_WIDTH`, `UCODE_CNT_WIDTH` (16): loop range width.
- `clk_i` in 1: clock; single clock domain.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `test_mode_i` in 1: unused functionally, kept for uniformity.
- `clear_i` in 1: synchronous clear, same effect as reset.
- `start_i` in 1: begin (or restart) an image load.
- `lock_i` in 1: engine busy (its enable); blocks commit.
- `cfg_data_i` in 32: image word.
- `cfg_valid_i` in 1 / `cfg_ready_o` out 1: word handshake; transfer when both high.
- `ucode_o` out `ucode_t`: committed microcode (code, loops, range).
- `ucode_valid_o` out 1: a committed image is present.
- `busy_o` out 1: FSM not in IDLE.
- `err_o` out 1: sticky, last image rejected.

## Operation
- Image layout, fixed order: CODE words, then LOOP words, then RANGE words.
  - CODE: 2 entries/word, entry k at bits [16*(k%2)+10 : 16*(k%2)]: {op_sel[10], a[9:5], b[4:0]}; LENGTH/2 = 8 words.
  - LOOP: 4 loops/word, loop l at byte l%4: {nb_ops[6:4], ucode_addr[3:0]}, bit 7 ignored; ceil(NB_LOOPS/4) = 2 words.
  - RANGE: 2 ranges/word, range l at bits [16*(l%2)+15 : 16*(l%2)]; ceil(NB_LOOPS/2) = 3 words.
  - Total 13 words; word counter `$clog2(13)` bits, per-section bases derived from parameters.
- FSM states: IDLE, CODE, LOOPS, RANGES, COMMIT.
  - IDLE: `cfg_ready_o`=0. `start_i` -> CODE, word counter 0, `err_o` cleared.
  - CODE/LOOPS/RANGES: `cfg_ready_o`=1; each transfer writes the shadow and increments the counter; the last word of a section advances to the next state; the last RANGE word -> COMMIT.
  - COMMIT: `cfg_ready_o`=0. Check, for every loop: nb_ops != 0, ucode_addr + nb_ops <= LENGTH (5-bit sum, no wrap), range != 0. If `lock_i`=1, stay in COMMIT. Else if the check passes: active <= shadow, `ucode_valid_o` <= 1, -> IDLE. If it fails: active unchanged, `err_o` <= 1, -> IDLE.
- `start_i` in any non-IDLE state aborts and restarts at CODE word 0; the shadow is not cleared (it is fully overwritten).
- `start_i` and a transfer in the same cycle: `start_i` wins and the word is dropped.
- Unused code slots receive zeros only if the image provides them; no implicit fill.

## Timing
- Reset/clear: state IDLE, counter 0, shadow and `ucode_o` all zero, `ucode_valid_o`=0, `err_o`=0, `busy_o`=0, `cfg_ready_o`=0.
- `cfg_ready_o` is a registered-state decode, combinational from the state only and never from `cfg_valid_i`.
- `start_i` at edge t gives `cfg_ready_o`=1 from cycle t+1.
- Last word accepted at edge t: COMMIT during t+1. With `lock_i`=0, `ucode_o`/`ucode_valid_o` update at edge t+1 and are visible from t+2. Each lock cycle adds 1.
- `ucode_o` changes only on a successful commit or on clear.
- `busy_o` is combinational from the state.

## Structure
- Package `hwpe_ctrl_package`: `ucode_t`, `ucode_code_t`, `ucode_loop_t`, UCODE_* constants, and the image section word counts as localparams/functions.
- Sub-module `hwpe_ctrl_ucode_checker`: combinational validity check of the shadow `ucode_t`, output pass/fail.

## Test plan
- Full valid image (loop0 addr 0 nb_ops 2, ranges all 3, others addr 2 nb_ops 1), `lock_i`=0 -> `ucode_valid_o`=1 two cycles after the 13th word; `ucode_o` fields match bit-for-bit; `err_o`=0.
- Same image with `lock_i`=1 for 5 cycles after the last word -> commit delayed exactly 5 cycles; `cfg_ready_o`=0 throughout.
- Loop 3 with addr 14, nb_ops 3 (sum 17 > 16) -> `err_o`=1, previous `ucode_o` retained, `ucode_valid_o` unchanged.
- `start_i` pulsed after 6 words, then a full 13-word image -> only the new image is committed; the first 6 words have no effect.
- Random `cfg_valid_i` gaps (50% duty) -> identical commit to the gap-free run; no word lost or duplicated.
- `clear_i` mid-RANGES after a prior commit -> next cycle all outputs are zero, state IDLE, `ucode_valid_o`=0.
